entry_controller: RTL and testbench

ENTRY_CONTROLLER -- requirements
Module: entry_controller

---
 rtl/entry_pkg.sv | 33 +++
 rtl/inactivity_timer.sv | 40 ++++
 rtl/entry_controller.sv | 154 +++++++++++++++
 tb/tb_entry_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/entry_pkg.sv
// Purpose: shared types and constants for the keypad entry controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package entry_pkg;

    // Width of the accumulated value handed to the downstream register.
    localparam int DATA_W = 14;
    // Width of the per-entry digit counter (MAX_DIGITS must stay below 8).
    localparam int CNT_W  = 3;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // acc*10 + d using shifts; callers guarantee acc <= 999 so nothing is lost.
    function automatic logic [DATA_W-1:0] times10_plus(input logic [DATA_W-1:0] acc,
                                                       input logic [3:0]        d);
        logic [DATA_W-1:0] sum;
        sum = (acc << 3) + (acc << 1) + {{(DATA_W-4){1'b0}}, d};
        return sum;
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Purpose: counts idle cycles while enabled and flags when the idle limit is reached.
// Latency: expired rises combinationally once the count reaches TIMEOUT_CYCLES-1.
// Backpressure: none; restart wins over counting, disable holds the count at zero.
//
// Ports:
//   clk      system clock
//   clr      asynchronous active-high reset
//   restart  zero the count this cycle (an accepted key)
//   enable   count only while high; count is held at zero otherwise
//   expired  high while enabled and the count equals TIMEOUT_CYCLES-1
module inactivity_timer #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    assign expired = enable && (count == LAST);

    // Clearing on expiry keeps the count in range even for the single
    // cycle the controller still spends in ENTRY after the limit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (restart || !enable || expired) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/entry_controller.sv
// Purpose: accumulates decimal keypad digits and drives load/clear/set strobes to a 14-bit register.
// Latency: a key sampled at edge k raises its strobe from edge k to k+1 (register captures at k+1).
// Backpressure: busy is high for the single COMMIT cycle; any key presented then is dropped.
//
// Ports:
//   clk          system clock
//   clr          asynchronous active-high reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     0-9 digit, A clear, B enter, C-F ignored
//   reg_d        accumulated value, continuously presented to the register
//   reg_enter    one-cycle load strobe
//   reg_clr      one-cycle clear strobe
//   reg_set      one-cycle set-all-ones strobe (overflow marker)
//   digit_count  digits accepted in the current entry
//   busy         high during COMMIT
module entry_controller
    import entry_pkg::*;
#(
    parameter int MAX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic [DATA_W-1:0] reg_d,
    output logic              reg_enter,
    output logic              reg_clr,
    output logic              reg_set,
    output logic [CNT_W-1:0]  digit_count,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic enter_nxt, clr_nxt, set_nxt, busy_nxt;
    logic key_ok, key_digit, key_clear, key_enter;
    logic restart, expired;

    // Keys are dropped during COMMIT; elsewhere every valid key is decoded.
    assign key_ok    = key_valid && (state != ST_COMMIT);
    assign key_digit = key_ok && is_digit(key_code);
    assign key_clear = key_ok && (key_code == KEY_CLEAR);
    assign key_enter = key_ok && (key_code == KEY_ENTER);

    // Codes C-F are not accepted keys and therefore leave the timer running.
    assign restart = key_digit || key_clear || key_enter;

    inactivity_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .enable  (state == ST_ENTRY),
        .expired (expired)
    );

    // State and datapath register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (key_digit) begin
                    acc_nxt   = {{(DATA_W-4){1'b0}}, key_code};
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                // Any accepted key takes priority over a simultaneous timeout.
                if (key_digit) begin
                    if (cnt < CNT_W'(MAX_DIGITS)) begin
                        acc_nxt = times10_plus(acc, key_code);
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        state_nxt = ST_ERROR;
                    end
                end else if (key_clear) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (key_enter) begin
                    state_nxt = ST_COMMIT;
                end else if (expired) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                if (key_clear) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs. Clear never coincides with a
    // move into COMMIT or ERROR, so at most one strobe is ever set.
    always_comb begin
        enter_nxt = (state == ST_ENTRY) && (state_nxt == ST_COMMIT);
        set_nxt   = (state == ST_ENTRY) && (state_nxt == ST_ERROR);
        clr_nxt   = key_clear;
        busy_nxt  = (state_nxt == ST_COMMIT);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            reg_enter <= 1'b0;
            reg_clr   <= 1'b0;
            reg_set   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_enter <= enter_nxt;
            reg_clr   <= clr_nxt;
            reg_set   <= set_nxt;
            busy      <= busy_nxt;
        end
    end

    assign reg_d       = acc;
    assign digit_count = cnt;

endmodule

// File: tb/tb_entry_controller.sv
module tb_entry_controller;
    import entry_pkg::*;

    logic        clk;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] reg_d;
    logic        reg_enter;
    logic        reg_clr;
    logic        reg_set;
    logic [2:0]  digit_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int onehot_viol = 0;
    logic [2:0] strobe_seen;
    int enters;

    entry_controller #(
        .MAX_DIGITS     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .reg_d       (reg_d),
        .reg_enter   (reg_enter),
        .reg_clr     (reg_clr),
        .reg_set     (reg_set),
        .digit_count (digit_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (32'(reg_enter) + 32'(reg_clr) + 32'(reg_set) > 1) onehot_viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string t, input int d, input int en, input int cl,
                              input int st, input int cnt, input int bz);
        check({t, ".reg_d"},       32'(reg_d),       d);
        check({t, ".reg_enter"},   32'(reg_enter),   en);
        check({t, ".reg_clr"},     32'(reg_clr),     cl);
        check({t, ".reg_set"},     32'(reg_set),     st);
        check({t, ".digit_count"}, 32'(digit_count), cnt);
        check({t, ".busy"},        32'(busy),        bz);
    endtask

    // Called at a falling edge; presents one key for exactly one rising edge.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            strobe_seen = strobe_seen | {reg_enter, reg_clr, reg_set};
        end
    endtask

    initial begin
        clr = 1'b1; key_valid = 1'b0; key_code = 4'h0; strobe_seen = '0;
        #1;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        expect_out("post_reset", 0, 0, 0, 0, 0, 0);

        // IDLE: ENTER ignored, CLEAR pulses reg_clr
        press(KEY_ENTER); expect_out("idle_enter", 0, 0, 0, 0, 0, 0);
        press(KEY_CLEAR); expect_out("idle_clear", 0, 0, 1, 0, 0, 0);

        // 1,2,3,4,ENTER
        press(4'd1); expect_out("t1_k1", 1, 0, 0, 0, 1, 0);
        press(4'd2); expect_out("t1_k2", 12, 0, 0, 0, 2, 0);
        press(4'd3); expect_out("t1_k3", 123, 0, 0, 0, 3, 0);
        press(4'd4); expect_out("t1_k4", 1234, 0, 0, 0, 4, 0);
        press(KEY_ENTER); expect_out("t1_commit", 1234, 1, 0, 0, 4, 1);
        idle(1); expect_out("t1_after", 0, 0, 0, 0, 0, 0);

        // 9,9,9,9,9 overflow -> ERROR
        for (int i = 0; i < 4; i++) press(4'd9);
        expect_out("t2_full", 9999, 0, 0, 0, 4, 0);
        press(4'd9); expect_out("t2_set", 9999, 0, 0, 1, 4, 0);
        idle(10); expect_out("t2_err_hold", 9999, 0, 0, 0, 4, 0);
        press(KEY_ENTER); expect_out("t2_err_enter", 9999, 0, 0, 0, 4, 0);
        press(4'd3); expect_out("t2_err_digit", 9999, 0, 0, 0, 4, 0);
        press(KEY_CLEAR); expect_out("t2_err_clear", 0, 0, 1, 0, 0, 0);
        press(4'd6); expect_out("t2_idle_again", 6, 0, 0, 0, 1, 0);
        press(KEY_CLEAR);

        // 5,CLEAR
        press(4'd5); expect_out("t3_k5", 5, 0, 0, 0, 1, 0);
        press(KEY_CLEAR); expect_out("t3_clear", 0, 0, 1, 0, 0, 0);
        idle(1); expect_out("t3_after", 0, 0, 0, 0, 0, 0);

        // timeout after 8 idle cycles, no strobes
        press(4'd7); expect_out("t4_k7", 7, 0, 0, 0, 1, 0);
        strobe_seen = '0;
        idle(7); expect_out("t4_before", 7, 0, 0, 0, 1, 0);
        idle(1); expect_out("t4_timeout", 0, 0, 0, 0, 0, 0);
        check("t4_no_strobe", 32'(strobe_seen), 0);

        // ignored code does not restart the timer
        press(4'd7);
        idle(3);
        press(4'hC); expect_out("t4_ign", 7, 0, 0, 0, 1, 0);
        idle(3); expect_out("t4_ign_hold", 7, 0, 0, 0, 1, 0);
        idle(1); expect_out("t4_ign_timeout", 0, 0, 0, 0, 0, 0);

        // key arriving on the expiry cycle wins and restarts the timer
        press(4'd7);
        idle(7);
        press(4'd3); expect_out("t4_race", 73, 0, 0, 0, 2, 0);
        idle(7); expect_out("t4_race_hold", 73, 0, 0, 0, 2, 0);
        idle(1); expect_out("t4_race_timeout", 0, 0, 0, 0, 0, 0);

        // reset during COMMIT
        press(4'd4); press(4'd2);
        press(KEY_ENTER); expect_out("t5_commit", 42, 1, 0, 0, 2, 1);
        clr = 1'b1;
        #1; expect_out("t5_async", 0, 0, 0, 0, 0, 0);
        @(negedge clk); clr = 1'b0;
        @(negedge clk); expect_out("t5_release", 0, 0, 0, 0, 0, 0);

        // reset during ERROR
        for (int i = 0; i < 5; i++) press(4'd9);
        expect_out("t5_err_set", 9999, 0, 0, 1, 4, 0);
        clr = 1'b1;
        #1; expect_out("t5_err_async", 0, 0, 0, 0, 0, 0);
        @(negedge clk); clr = 1'b0;
        @(negedge clk); expect_out("t5_err_release", 0, 0, 0, 0, 0, 0);
        press(4'd6); expect_out("t5_err_idle", 6, 0, 0, 0, 1, 0);
        press(KEY_CLEAR);

        // ENTER held across COMMIT: second one dropped
        press(4'd8);
        key_valid = 1'b1; key_code = KEY_ENTER;
        @(negedge clk);
        enters = 32'(reg_enter);
        expect_out("t6_commit", 8, 1, 0, 0, 1, 1);
        @(negedge clk);
        enters += 32'(reg_enter);
        expect_out("t6_held", 0, 0, 0, 0, 0, 0);
        key_valid = 1'b0; key_code = 4'h0;
        @(negedge clk);
        enters += 32'(reg_enter);
        check("t6_enter_count", 32'(enters), 1);

        check("onehot_strobes", 32'(onehot_viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
